dm_store_rmw: RTL and testbench
===============================

Name: dm_store_rmw

Overview:
- Store-side counterpart of the load-extension path. It takes `sw`/`sh`/`sb` requests from the MEM stage and drives a word-wide synchronous data memory that has no byte enables.
- `sw` is written directly in one cycle.
- `sh`/`sb` use a two-cycle read-modify-write sequence. This block stalls the pipeline for the extra cycle and flags misaligned stores.
- Sits between the MEM-stage pipeline register and the DM write port. Loads use a separate DM read path.

Parameters:
- ADDR_W, 32, byte address width
- CNT_W, 32, width of the sub-word store counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- req_valid  in  1  store request present in MEM this cycle
- mod  in  3  store type: 3'd0 word, 3'd1 byte, 3'd2 half; other codes are no-op
- addr  in  ADDR_W  byte address
- wdata  in  32  store data (GPR rt, unshifted)
- stall  out  1  hold MEM/WB and earlier stages this cycle
- align_err  out  1  misaligned store (AdES), combinational, same cycle as request
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_re  out  1  read strobe for RMW; data returns the next cycle
- mem_rdata  in  32  DM read data, valid the cycle after mem_re
- mem_we  out  1  word write strobe
- mem_wdata  out  32  word write data
- sub_cnt  out  CNT_W  count of completed sub-word stores

Behaviour:
- FSM states: IDLE, MERGE. On reset: state=IDLE, captured regs=0, sub_cnt=0. All strobes (stall, align_err, mem_re, mem_we) are 0 while reset==0, and mem_wdata=0.
- Misaligned condition:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - byte is never misaligned
- IDLE, req_valid=0 or mod invalid: all strobes 0, stay in IDLE.
- IDLE, req_valid=1, misaligned: align_err=1, no mem_re/mem_we, stall=0, stay in IDLE.
- IDLE, word aligned:
  - mem_we=1, mem_wdata=wdata, mem_addr from addr, same cycle.
  - stall=0, stay in IDLE.
  - Latency 0, no stall.
- IDLE, byte/half aligned:
  - mem_re=1, mem_addr from addr, stall=1.
  - Capture addr[ADDR_W-1:0], mod and wdata into regs; go to MERGE.
- MERGE:
  - Inputs are ignored; the request is still held by the stall and is not re-accepted.
  - mem_addr comes from the captured addr, mem_we=1, stall=0, mem_re=0.
  - mem_wdata = mem_rdata with one lane replaced:
    - byte: lane addr[1:0]; bits [8k+7:8k] = wdata[7:0], where k = addr[1:0].
    - half: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0].
  - sub_cnt increments by 1 (wraps modulo 2^CNT_W); go to IDLE.
  - The pipeline advances at the end of MERGE, so a sub-word store costs 1 stall cycle.
- Back-to-back stores: a new request is first seen in the IDLE cycle after MERGE. sb followed by sb to the same word must observe the first write; DM write-then-read ordering guarantees this.
- Reset==0 in MERGE: return to IDLE and suppress mem_we; the partial store is dropped.
- mem_wdata is don't-care when mem_we=0; drive it to 0.

Test Plan:
- Reset held 2 cycles, then released with req_valid=0 -> stall=0, mem_we=0, mem_re=0, sub_cnt=0.
- sw addr=0x0000_0010, wdata=0xDEADBEEF -> same cycle mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, stall=0.
- sb addr=0x0000_0013, wdata=0x000000AB, mem_rdata=0x11223344 -> cycle 0: mem_re=1, stall=1. Cycle 1: mem_we=1, mem_addr=0x10, mem_wdata=0xAB223344, sub_cnt=1.
- sh addr=0x0000_0006, wdata=0x0000CAFE, mem_rdata=0x11223344 -> MERGE mem_addr=0x4, mem_wdata=0xCAFE3344. Then sh addr=0x4 back-to-back -> second MERGE replaces [15:0].
- sh addr=0x5 and sw addr=0x2 -> align_err=1 each cycle, mem_we=0, mem_re=0, stall=0, sub_cnt unchanged.
- sb addr=0x1; assert reset==0 during MERGE -> mem_we=0 that cycle, state IDLE, sub_cnt=0 after reset.

Source files
------------

// File: rtl/dm_store_rmw.sv
// Store path to a word-wide data memory without byte enables: sw written directly, sb/sh via read-modify-write.
// Latency: sw writes in the request cycle; sb/sh read in the request cycle and write merged data one cycle later.
// Backpressure: stall is raised for the single read cycle of a sub-word store; no other flow control.
module dm_store_rmw #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        mod,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              align_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  sub_cnt
);

    localparam logic [2:0] MOD_WORD = 3'd0;
    localparam logic [2:0] MOD_BYTE = 3'd1;
    localparam logic [2:0] MOD_HALF = 3'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               half_q, half_d;     // captured store is a halfword (else byte)
    logic [15:0]        sdata_q, sdata_d;   // only the low halfword of rt can reach memory
    logic [CNT_W-1:0]   sub_cnt_q, sub_cnt_d;

    // Request decode for the cycle the store is first seen in IDLE
    logic is_word, is_byte, is_half, misaligned, start_rmw;

    always_comb begin
        is_word    = req_valid && (mod == MOD_WORD);
        is_byte    = req_valid && (mod == MOD_BYTE);
        is_half    = req_valid && (mod == MOD_HALF);
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        start_rmw  = (is_byte || is_half) && !misaligned;
    end

    // State and captured-request registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            half_q    <= 1'b0;
            sdata_q   <= '0;
            sub_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            half_q    <= half_d;
            sdata_q   <= sdata_d;
            sub_cnt_q <= sub_cnt_d;
        end
    end

    // Next state: IDLE launches a read for aligned sb/sh, MERGE always returns after its write
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        half_d    = half_q;
        sdata_d   = sdata_q;
        sub_cnt_d = sub_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rmw) begin
                    state_d = ST_MERGE;
                    addr_d  = addr;
                    half_d  = is_half;
                    sdata_d = wdata[15:0];
                end
            end
            ST_MERGE: begin
                state_d   = ST_IDLE;
                sub_cnt_d = sub_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: strobes and write data are forced low while reset is asserted
    always_comb begin
        stall     = 1'b0;
        align_err = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = {addr[ADDR_W-1:2], 2'b00};
        if (state_q == ST_MERGE) begin
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (reset) begin
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
                if (half_q) begin
                    if (addr_q[1]) mem_wdata[31:16] = sdata_q;
                    else           mem_wdata[15:0]  = sdata_q;
                end else begin
                    case (addr_q[1:0])
                        2'd0:    mem_wdata[7:0]   = sdata_q[7:0];
                        2'd1:    mem_wdata[15:8]  = sdata_q[7:0];
                        2'd2:    mem_wdata[23:16] = sdata_q[7:0];
                        default: mem_wdata[31:24] = sdata_q[7:0];
                    endcase
                end
            end
        end else if (reset) begin
            if (misaligned) begin
                align_err = 1'b1;
            end else if (is_word) begin
                mem_we    = 1'b1;
                mem_wdata = wdata;
            end else if (start_rmw) begin
                mem_re = 1'b1;
                stall  = 1'b1;
            end
        end
    end

    assign sub_cnt = sub_cnt_q;

endmodule

// File: tb/tb_dm_store_rmw.sv
module tb_dm_store_rmw;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [2:0]        mod;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic              align_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [CNT_W-1:0]  sub_cnt;

    always #5 clk = ~clk;

    dm_store_rmw #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .mod       (mod),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .align_err (align_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .sub_cnt   (sub_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding sub-word store, described by what it will write
    bit          pend = 0;
    logic [31:0] p_addr;
    logic [2:0]  p_mod;
    logic [31:0] p_data;
    logic [31:0] m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Replace the addressed byte lanes of the old word with the low bytes of the store data
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] m, input logic [31:0] d);
        logic [31:0] r;
        int lo, n;
        r  = old;
        n  = (m == 3'd2) ? 2 : 1;
        lo = (m == 3'd2) ? int'(a[1]) * 2 : int'(a[1:0]);
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + n)
                r[8*i +: 8] = d[8*(i-lo) +: 8];
        return r;
    endfunction

    // Compare every output against the model for the current inputs, then advance the model
    task automatic check_cycle();
        logic e_stall, e_align, e_re, e_we;
        logic [31:0] e_wdata, e_addr;
        bit mis;
        e_stall = 0; e_align = 0; e_re = 0; e_we = 0; e_wdata = 0;
        e_addr  = addr & ~32'd3;
        chk("sub_cnt", sub_cnt, m_cnt);
        if (!reset) begin
            pend  = 0;
            m_cnt = 0;
        end else if (pend) begin
            e_we    = 1;
            e_addr  = p_addr & ~32'd3;
            e_wdata = merge(mem_rdata, p_addr, p_mod, p_data);
            pend    = 0;
            m_cnt   = m_cnt + 1;
        end else if (req_valid && mod <= 3'd2) begin
            mis = (mod == 3'd2 && addr % 2 != 0) || (mod == 3'd0 && addr % 4 != 0);
            if (mis) begin
                e_align = 1;
            end else if (mod == 3'd0) begin
                e_we    = 1;
                e_wdata = wdata;
            end else begin
                e_re    = 1;
                e_stall = 1;
                pend    = 1;
                p_addr  = addr;
                p_mod   = mod;
                p_data  = wdata;
            end
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("align_err", 32'(align_err), 32'(e_align));
        chk("mem_re", 32'(mem_re), 32'(e_re));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wdata", mem_wdata, e_wdata);
        if (reset) chk("mem_addr", mem_addr, e_addr);
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
        @(negedge clk);
        reset = r; req_valid = v; mod = m; addr = a; wdata = d; mem_rdata = rd;
        #1;
        check_cycle();
    endtask

    initial begin
        reset = 0; req_valid = 0; mod = 0; addr = 0; wdata = 0; mem_rdata = 0;

        // Reset held two cycles, then released idle
        step(0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);

        // sw aligned: same-cycle write
        step(1, 1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0);
        chk("sw_wdata_lit", mem_wdata, 32'hDEADBEEF);

        // sb to top byte lane
        step(1, 1, 3'd1, 32'h13, 32'h000000AB, 32'h0);
        chk("sb_stall_lit", 32'(stall), 32'd1);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h11223344);
        chk("sb_merge_lit", mem_wdata, 32'hAB223344);
        chk("sb_addr_lit", mem_addr, 32'h10);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("sb_cnt_lit", sub_cnt, 32'd1);

        // sh upper half, request still held during MERGE, then back-to-back sh lower half
        step(1, 1, 3'd2, 32'h6, 32'h0000CAFE, 32'h0);
        step(1, 1, 3'd2, 32'h6, 32'h0000CAFE, 32'h11223344);
        chk("sh_hi_lit", mem_wdata, 32'hCAFE3344);
        chk("sh_hi_addr_lit", mem_addr, 32'h4);
        step(1, 1, 3'd2, 32'h4, 32'h0000BEEF, 32'h0);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'hCAFE3344);
        chk("sh_lo_lit", mem_wdata, 32'hCAFEBEEF);

        // Misaligned stores
        step(1, 1, 3'd2, 32'h5, 32'h1234, 32'h0);
        chk("ades_sh_lit", 32'(align_err), 32'd1);
        step(1, 1, 3'd0, 32'h2, 32'h1234, 32'h0);
        chk("ades_sw_lit", 32'(align_err), 32'd1);
        step(1, 1, 3'd1, 32'h3, 32'h77, 32'h0);   // byte never misaligned
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);

        // Randomized traffic, occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), m,
                 $urandom & 32'hFF, $urandom, $urandom);
        end
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);

        // Reset during MERGE drops the partial store
        step(1, 1, 3'd1, 32'h1, 32'h55, 32'h0);
        step(0, 0, 3'd0, 32'h0, 32'h0, 32'h11223344);
        chk("rst_merge_we_lit", 32'(mem_we), 32'd0);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("rst_cnt_lit", sub_cnt, 32'd0);
        step(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
